// File: rtl/stopwatch_ctrl_if.sv
// ----------------------------------------------------------------------------
// stopwatch_ctrl_if
// Link between the stopwatch control stage and the 4-digit BCD down counter.
//   en       : decrement strobe, controller -> counter
//   rst      : one-cycle active-high reload pulse, controller -> counter
//   cnt_zero : counter shows all zeros, counter -> controller
// Modports: master = control stage, slave = counter.
// ----------------------------------------------------------------------------
interface stopwatch_ctrl_if;
    logic en;
    logic rst;
    logic cnt_zero;

    modport master (output en, output rst, input cnt_zero);
    modport slave  (input en, input rst, output cnt_zero);
endinterface

// File: rtl/stopwatch_ctrl.sv
// ----------------------------------------------------------------------------
// stopwatch_ctrl
// Turns two raw push-buttons and a 1 Hz strobe into the down counter's
// decrement strobe and reload pulse. Each button is synchronized, debounced
// on sample_tick and turned into a one-clk press event. A run/pause/done FSM
// gates sec_tick so the counter decrements once per second while running and
// stops at zero.
//
// Ports:
//   clk          in   single clock
//   rst_n        in   synchronous active-low reset
//   sample_tick  in   debounce sampling strobe (one clk wide)
//   sec_tick     in   1 Hz count strobe (one clk wide)
//   pb_start     in   raw start/pause button, asynchronous, active-high
//   pb_reset     in   raw reset button, asynchronous, active-high
//   cnt_if       master modport: en/rst out, cnt_zero in
//   state        out  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3
//
// Parameters:
//   DB_LEN        debounce depth in consecutive equal samples (>= 2)
//   HOLD_SAMPLES  sample_tick count that makes a long press
//
// Optional feature macro: STOPWATCH_LONG_PRESS_EN
//   When defined, holding start for HOLD_SAMPLES samples after it debounces
//   issues one reset event, exactly as if the reset button had been pressed.
// ----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int DB_LEN       = 4,
    parameter int HOLD_SAMPLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_tick,
    input  logic                    sec_tick,
    input  logic                    pb_start,
    input  logic                    pb_reset,
    stopwatch_ctrl_if.master        cnt_if,
    output logic [1:0]              state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Bit 0 = start button, bit 1 = reset button.
    logic [1:0]        pb_raw;
    logic [1:0]        sync_p0;
    logic [1:0]        sync_p1;
    logic [DB_LEN-1:0] db_sh     [2];
    logic [DB_LEN-1:0] db_sh_nxt [2];
    logic [1:0]        db_lvl;
    logic [1:0]        db_lvl_d;
    logic [1:0]        ev;
    logic              start_ev;
    logic              reset_ev;
    logic              long_ev;
    logic              any_reset;
    logic [1:0]        state_nxt;
    logic              rst_q;

    assign pb_raw = {pb_reset, pb_start};

    // ---- Synchronizer stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= pb_raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- Debounce stage
    // The level is decided on the post-shift value so it flips on the same
    // clk as the DB_LEN-th agreeing sample.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            db_sh_nxt[b] = {db_sh[b][DB_LEN-2:0], sync_p1[b]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                db_sh[b] <= '0;
            end
            db_lvl <= '0;
        end else if (sample_tick) begin
            for (int b = 0; b < 2; b++) begin
                db_sh[b] <= db_sh_nxt[b];
                if (&db_sh_nxt[b]) begin
                    db_lvl[b] <= 1'b1;
                end else if (~|db_sh_nxt[b]) begin
                    db_lvl[b] <= 1'b0;
                end
            end
        end
    end

    // ---- One-shot stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_lvl_d <= '0;
            ev       <= '0;
        end else begin
            db_lvl_d <= db_lvl;
            ev       <= db_lvl & ~db_lvl_d;
        end
    end

    assign start_ev = ev[0];
    assign reset_ev = ev[1];

`ifdef STOPWATCH_LONG_PRESS_EN
    // ---- Long-press stage
    // Counts samples while debounced start is held; saturates at
    // HOLD_SAMPLES so a single hold yields a single reset.
    localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);

    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            long_ev  <= 1'b0;
        end else begin
            long_ev <= 1'b0;
            if (!db_lvl[0]) begin
                hold_cnt <= '0;
            end else if (sample_tick && (hold_cnt != HOLD_W'(HOLD_SAMPLES))) begin
                hold_cnt <= hold_cnt + 1'b1;
                long_ev  <= (hold_cnt == HOLD_W'(HOLD_SAMPLES - 1));
            end
        end
    end
`else
    assign long_ev = 1'b0;
`endif

    assign any_reset = reset_ev | long_ev;

    // ---- FSM stage
    // Reset wins over everything; reaching zero in RUN wins over start.
    always_comb begin
        state_nxt = state;
        if (any_reset) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_ev) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (cnt_if.cnt_zero)  state_nxt = ST_DONE;
                    else if (start_ev)    state_nxt = ST_PAUSE;
                end
                ST_PAUSE: if (start_ev) state_nxt = ST_RUN;
                default:  state_nxt = state;
            endcase
        end
    end

    // rst_n does not pulse rst: the counter sees rst_n itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            rst_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rst_q <= any_reset;
        end
    end

    assign cnt_if.rst = rst_q;
    assign cnt_if.en  = (state == ST_RUN) & sec_tick & ~cnt_if.cnt_zero;

endmodule
